// File: rtl/mole_hit_scorer.sv
// mole_hit_scorer
// Judges per-hole player presses against the active mole bitmap. A press on an
// active mole that has not been hit yet in this round knocks it down and scores.
// Any other press counts as a miss and starts a penalty lockout.
//
// Optional feature: define MOLE_COMBO_EN to enable the hit streak and combo
// scoring. When the streak is at least COMBO_THRESHOLD before a hit cycle,
// each hit in that cycle scores 2. Without the macro, streak is tied to 0,
// every hit scores 1, and no streak logic is built.
module mole_hit_scorer #(
    parameter int NUMBER_OF_HOLES = 18,
    parameter int SCORE_WIDTH     = 10,
    parameter int MISS_WIDTH      = 8,
    parameter int LOCKOUT_CYCLES  = 25,
    parameter int COMBO_THRESHOLD = 3,
    localparam int HP_W = (NUMBER_OF_HOLES > 1) ? $clog2(NUMBER_OF_HOLES) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       game_active,
    input  logic [NUMBER_OF_HOLES-1:0] mole_positions,
    input  logic [NUMBER_OF_HOLES-1:0] buttons,
    output logic [NUMBER_OF_HOLES-1:0] visible_moles,
    output logic [NUMBER_OF_HOLES-1:0] whacked,
    output logic [SCORE_WIDTH-1:0]     score,
    output logic [MISS_WIDTH-1:0]      misses,
    output logic                       hit_pulse,
    output logic                       miss_pulse,
    output logic [HP_W-1:0]            hit_position,
    output logic [7:0]                 streak,
    output logic                       locked_out
);

    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

`ifdef MOLE_COMBO_EN
    localparam bit COMBO_EN = 1'b1;
`else
    localparam bit COMBO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAY    = 2'd1,
        S_LOCKOUT = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [NUMBER_OF_HOLES-1:0] btn_prev_q;
    logic [NUMBER_OF_HOLES-1:0] whacked_q, whacked_d;
    logic [SCORE_WIDTH-1:0]     score_q, score_d;
    logic [MISS_WIDTH-1:0]      misses_q, misses_d;
    logic [LOCK_W-1:0]          lock_cnt_q, lock_cnt_d;
    logic                       hit_pulse_q, hit_pulse_d;
    logic                       miss_pulse_q, miss_pulse_d;
    logic [HP_W-1:0]            hit_pos_q, hit_pos_d;

    logic [NUMBER_OF_HOLES-1:0] press;
    logic [NUMBER_OF_HOLES-1:0] avail;
    logic [NUMBER_OF_HOLES-1:0] hits;
    logic [NUMBER_OF_HOLES-1:0] bad;
    logic                       in_play;
    logic [7:0]                 hit_cnt;
    logic [7:0]                 points;
    logic [7:0]                 streak_cur;
    logic                       combo_on;

    // Number of set bits in a hole vector.
    function automatic logic [7:0] popcount(input logic [NUMBER_OF_HOLES-1:0] v);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < NUMBER_OF_HOLES; i++) begin
            cnt = cnt + {7'd0, v[i]};
        end
        return cnt;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [HP_W-1:0] lowest_index(input logic [NUMBER_OF_HOLES-1:0] v);
        logic [HP_W-1:0] idx;
        idx = '0;
        for (int i = NUMBER_OF_HOLES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = HP_W'(i);
            end
        end
        return idx;
    endfunction

    // Score addition that sticks at all-ones instead of wrapping.
    function automatic logic [SCORE_WIDTH-1:0] sat_add_score(input logic [SCORE_WIDTH-1:0] a,
                                                             input logic [7:0]             b);
        logic [SCORE_WIDTH+8:0] sum;
        sum = {9'd0, a} + {{(SCORE_WIDTH + 1){1'b0}}, b};
        if (sum[SCORE_WIDTH+8:SCORE_WIDTH] != '0) begin
            return '1;
        end
        return sum[SCORE_WIDTH-1:0];
    endfunction

    // Miss counter increment that sticks at all-ones.
    function automatic logic [MISS_WIDTH-1:0] sat_inc_miss(input logic [MISS_WIDTH-1:0] a);
        if (&a) begin
            return a;
        end
        return a + MISS_WIDTH'(1);
    endfunction

`ifdef MOLE_COMBO_EN
    // Streak addition that sticks at 255.
    function automatic logic [7:0] sat_add_streak(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[8]) begin
            return 8'hFF;
        end
        return sum[7:0];
    endfunction
`endif

    // Press edges and the per-cycle classification of presses into hits and misses.
    always_comb begin
        press    = buttons & ~btn_prev_q;
        avail    = mole_positions & ~whacked_q;
        in_play  = (state_q == S_PLAY) && game_active;
        hits     = in_play ? (press & avail) : '0;
        bad      = in_play ? (press & ~avail) : '0;
        hit_cnt  = popcount(hits);
        combo_on = COMBO_EN && (streak_cur >= 8'(COMBO_THRESHOLD));
        points   = combo_on ? {hit_cnt[6:0], 1'b0} : hit_cnt;
    end

    // Next-state logic for the game FSM and the score/miss/whacked bookkeeping.
    always_comb begin
        state_d      = state_q;
        whacked_d    = whacked_q & mole_positions;
        score_d      = score_q;
        misses_d     = misses_q;
        lock_cnt_d   = lock_cnt_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        hit_pos_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (game_active) begin
                    score_d   = '0;
                    misses_d  = '0;
                    whacked_d = '0;
                    state_d   = S_PLAY;
                end
            end

            S_PLAY: begin
                if (!game_active) begin
                    state_d = S_IDLE;
                end else begin
                    // Hits are scored first; a miss in the same cycle still locks out.
                    if (hits != '0) begin
                        whacked_d   = (whacked_q | hits) & mole_positions;
                        score_d     = sat_add_score(score_q, points);
                        hit_pulse_d = 1'b1;
                        hit_pos_d   = lowest_index(hits);
                    end
                    if (bad != '0) begin
                        misses_d     = sat_inc_miss(misses_q);
                        miss_pulse_d = 1'b1;
                        lock_cnt_d   = LOCK_LOAD;
                        state_d      = S_LOCKOUT;
                    end
                end
            end

            S_LOCKOUT: begin
                if (!game_active) begin
                    state_d = S_IDLE;
                end else if (lock_cnt_q == '0) begin
                    state_d = S_PLAY;
                end else begin
                    lock_cnt_d = lock_cnt_q - LOCK_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; btn_prev follows the buttons in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            btn_prev_q   <= '0;
            whacked_q    <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            lock_cnt_q   <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            hit_pos_q    <= '0;
        end else begin
            state_q      <= state_d;
            btn_prev_q   <= buttons;
            whacked_q    <= whacked_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            lock_cnt_q   <= lock_cnt_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            hit_pos_q    <= hit_pos_d;
        end
    end

`ifdef MOLE_COMBO_EN
    logic [7:0] streak_q, streak_d;

    // Streak grows by the number of moles hit and is wiped by any miss or a new game.
    always_comb begin
        streak_d = streak_q;
        if (state_q == S_IDLE) begin
            if (game_active) begin
                streak_d = '0;
            end
        end else if (in_play) begin
            if (hits != '0) begin
                streak_d = sat_add_streak(streak_q, hit_cnt);
            end
            if (bad != '0) begin
                streak_d = '0;
            end
        end
    end

    // Streak register.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign streak_cur = streak_q;
`else
    assign streak_cur = 8'd0;
`endif

    assign visible_moles = mole_positions & ~whacked_q;
    assign whacked       = whacked_q;
    assign score         = score_q;
    assign misses        = misses_q;
    assign hit_pulse     = hit_pulse_q;
    assign miss_pulse    = miss_pulse_q;
    assign hit_position  = hit_pos_q;
    assign streak        = streak_cur;
    assign locked_out    = (state_q == S_LOCKOUT);

endmodule

// File: tb/tb_mole_hit_scorer.sv
// Testbench for mole_hit_scorer: directed vectors with literal expectations plus
// a behavioural reference model checked against the DUT on every cycle.
// Define MOLE_COMBO_EN for both files to exercise the combo-scoring build.
module tb_mole_hit_scorer;

    localparam int H       = 18;
    localparam int SW      = 10;
    localparam int MW      = 8;
    localparam int LOCK    = 25;
    localparam int THR     = 3;
    localparam int SMAX    = (1 << SW) - 1;
    localparam int MMAX    = (1 << MW) - 1;
    localparam logic [H-1:0] ALL = '1;
`ifdef MOLE_COMBO_EN
    localparam bit COMBO = 1'b1;
`else
    localparam bit COMBO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          game_active;
    logic [H-1:0]  mole_positions;
    logic [H-1:0]  buttons;
    logic [H-1:0]  visible_moles;
    logic [H-1:0]  whacked;
    logic [SW-1:0] score;
    logic [MW-1:0] misses;
    logic          hit_pulse;
    logic          miss_pulse;
    logic [4:0]    hit_position;
    logic [7:0]    streak;
    logic          locked_out;

    mole_hit_scorer dut (
        .clk            (clk),
        .reset          (reset),
        .game_active    (game_active),
        .mole_positions (mole_positions),
        .buttons        (buttons),
        .visible_moles  (visible_moles),
        .whacked        (whacked),
        .score          (score),
        .misses         (misses),
        .hit_pulse      (hit_pulse),
        .miss_pulse     (miss_pulse),
        .hit_position   (hit_position),
        .streak         (streak),
        .locked_out     (locked_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: game mode, score, misses, round bitmap and remaining lockout cycles.
    int           m_mode;       // 0 idle, 1 play, 2 lockout
    int           m_score;
    int           m_misses;
    int           m_streak;
    int           m_lock_left;
    int           m_pos;
    bit           m_hit;
    bit           m_miss;
    logic [H-1:0] m_whacked;
    logic [H-1:0] m_prev;
    logic [H-1:0] m_press;
    logic [H-1:0] m_avail;
    logic [H-1:0] m_hits;
    logic [H-1:0] m_bad;
    int           m_weight;
    int           m_pts;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_score = 0; m_misses = 0; m_streak = 0; m_lock_left = 0;
            m_pos = 0; m_hit = 0; m_miss = 0; m_whacked = '0; m_prev = '0;
        end else begin
            m_press = buttons & ~m_prev;
            m_hit = 0; m_miss = 0; m_pos = 0;
            if (m_mode == 0) begin
                if (game_active) begin
                    m_score = 0; m_misses = 0; m_whacked = '0; m_streak = 0; m_mode = 1;
                end
            end else if (!game_active) begin
                m_mode = 0;
            end else if (m_mode == 2) begin
                m_lock_left = m_lock_left - 1;
                if (m_lock_left == 0) m_mode = 1;
            end else begin
                m_avail = mole_positions & ~m_whacked;
                m_hits  = m_press & m_avail;
                m_bad   = m_press & ~m_avail;
                if (m_hits != '0) begin
                    m_weight = (COMBO && m_streak >= THR) ? 2 : 1;
                    m_pts = m_weight * $countones(m_hits);
                    for (int i = H - 1; i >= 0; i--) if (m_hits[i]) m_pos = i;
                    m_score = (m_score + m_pts > SMAX) ? SMAX : m_score + m_pts;
                    if (COMBO) m_streak = (m_streak + $countones(m_hits) > 255) ? 255
                                          : m_streak + $countones(m_hits);
                    m_whacked = m_whacked | m_hits;
                    m_hit = 1;
                end
                if (m_bad != '0) begin
                    m_misses = (m_misses == MMAX) ? MMAX : m_misses + 1;
                    m_miss = 1;
                    m_streak = 0;
                    m_mode = 2;
                    m_lock_left = LOCK;
                end
            end
            m_whacked = m_whacked & mole_positions;
            m_prev = buttons;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("visible_moles", 32'(visible_moles), 32'(mole_positions & ~m_whacked));
            chk("whacked", 32'(whacked), 32'(m_whacked));
            chk("score", 32'(score), m_score);
            chk("misses", 32'(misses), m_misses);
            chk("hit_pulse", 32'(hit_pulse), 32'(m_hit));
            chk("miss_pulse", 32'(miss_pulse), 32'(m_miss));
            if (m_hit) chk("hit_position", 32'(hit_position), m_pos);
            chk("streak", 32'(streak), m_streak);
            chk("locked_out", 32'(locked_out), 32'(m_mode == 2));
        end
    end

    task automatic apply(input logic ga, input logic [H-1:0] mp, input logic [H-1:0] btn);
        game_active    = ga;
        mole_positions = mp;
        buttons        = btn;
        @(posedge clk);
        #2;
    endtask

    // Sit out a lockout that began on the previous cycle, buttons released.
    task automatic wait_out(input logic [H-1:0] mp);
        repeat (LOCK) apply(1'b1, mp, '0);
        chk("lockout_end", 32'(locked_out), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        game_active = 1'b0; mole_positions = '0; buttons = '0;
        apply(1'b0, '0, '0);
        apply(1'b0, '0, '0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_misses", 32'(misses), 32'd0);
        chk("rst_whacked", 32'(whacked), 32'd0);
        chk("rst_locked", 32'(locked_out), 32'd0);
        chk("rst_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Start the game and hit hole 0.
        apply(1'b1, 18'h00005, '0);
        apply(1'b1, 18'h00005, 18'h00001);
        chk("first_hit_pulse", 32'(hit_pulse), 32'd1);
        chk("first_hit_pos", 32'(hit_position), 32'd0);
        chk("first_hit_score", 32'(score), 32'd1);
        chk("first_hit_whacked", 32'(whacked), 32'h1);
        chk("first_hit_visible", 32'(visible_moles), 32'h4);
        apply(1'b1, 18'h00005, '0);
        chk("pulse_one_cycle", 32'(hit_pulse), 32'd0);

        // Press an already-whacked mole: miss and lockout lasting 25 cycles.
        apply(1'b1, 18'h00005, 18'h00001);
        chk("rewhack_miss_pulse", 32'(miss_pulse), 32'd1);
        chk("rewhack_misses", 32'(misses), 32'd1);
        chk("rewhack_locked", 32'(locked_out), 32'd1);
        for (int k = 0; k < LOCK - 1; k++) begin
            apply(1'b1, 18'h00005, (k == 3) ? 18'h00004 : 18'h00000);
            chk("lockout_held", 32'(locked_out), 32'd1);
        end
        chk("lockout_press_ignored", 32'(score), 32'd1);
        apply(1'b1, 18'h00005, '0);
        chk("lockout_25_cycles", 32'(locked_out), 32'd0);

        // Blank round clears whacked; then simultaneous hits and a miss.
        apply(1'b1, '0, '0);
        chk("blank_clears_whacked", 32'(whacked), 32'd0);
        apply(1'b1, 18'h00005, '0);
        apply(1'b1, 18'h00005, 18'h00025);
        chk("mixed_score", 32'(score), 32'd3);
        chk("mixed_misses", 32'(misses), 32'd2);
        chk("mixed_pos", 32'(hit_position), 32'd0);
        chk("mixed_pulses", 32'({hit_pulse, miss_pulse}), 32'd3);
        chk("mixed_locked", 32'(locked_out), 32'd1);
        wait_out(18'h00005);

        apply(1'b1, '0, '0);
        chk("blank_clears_whacked2", 32'(whacked), 32'd0);
        apply(1'b1, 18'h00001, 18'h00001);
        chk("new_round_scores", 32'(score), 32'd4);
        apply(1'b1, 18'h00001, '0);

        // Held buttons never re-trigger: one hit, then one miss.
        repeat (10) apply(1'b1, 18'h00003, 18'h00002);
        chk("held_hit_once", 32'(score), 32'd5);
        apply(1'b1, 18'h00003, '0);
        repeat (30) apply(1'b1, 18'h00003, 18'h00010);
        chk("held_miss_once", 32'(misses), 32'd3);
        chk("held_miss_unlocked", 32'(locked_out), 32'd0);
        apply(1'b1, 18'h00003, '0);

        // Drive the score into saturation with full-board rounds.
        for (int r = 0; r < 60; r++) begin
            apply(1'b1, '0, '0);
            apply(1'b1, ALL, ALL);
        end
        chk("score_saturates", 32'(score), 32'd1023);
        apply(1'b1, '0, '0);
        apply(1'b1, ALL, ALL);
        chk("score_sat_hit_pulse", 32'(hit_pulse), 32'd1);
        chk("score_stays_1023", 32'(score), 32'd1023);

        // Drive the miss counter into saturation.
        apply(1'b1, '0, '0);
        for (int r = 0; r < 252; r++) begin
            apply(1'b1, '0, 18'h00001);
            wait_out('0);
        end
        chk("misses_saturate", 32'(misses), 32'd255);
        apply(1'b1, '0, 18'h00001);
        chk("misses_sat_pulse", 32'(miss_pulse), 32'd1);
        chk("misses_stay_255", 32'(misses), 32'd255);
        wait_out('0);

        // Game over holds counters and ignores presses; restart clears them.
        apply(1'b0, '0, '0);
        apply(1'b0, 18'h00001, '0);
        apply(1'b0, 18'h00001, 18'h00001);
        chk("idle_ignores_press", 32'(hit_pulse), 32'd0);
        chk("idle_score_holds", 32'(score), 32'd1023);
        chk("idle_misses_hold", 32'(misses), 32'd255);
        apply(1'b1, '0, '0);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_misses", 32'(misses), 32'd0);

`ifdef MOLE_COMBO_EN
        apply(1'b1, 18'h00007, 18'h00001);
        apply(1'b1, 18'h00007, '0);
        apply(1'b1, 18'h00007, 18'h00002);
        apply(1'b1, 18'h00007, '0);
        apply(1'b1, 18'h00007, 18'h00004);
        chk("combo_score3", 32'(score), 32'd3);
        chk("combo_streak3", 32'(streak), 32'd3);
        apply(1'b1, '0, '0);
        apply(1'b1, 18'h00001, 18'h00001);
        chk("combo_bonus_score", 32'(score), 32'd5);
        chk("combo_streak4", 32'(streak), 32'd4);
        apply(1'b1, 18'h00001, '0);
        apply(1'b1, 18'h00001, 18'h00001);
        chk("combo_miss_streak", 32'(streak), 32'd0);
        wait_out(18'h00001);
        apply(1'b1, '0, '0);
        apply(1'b1, 18'h00001, 18'h00001);
        chk("combo_after_miss", 32'(score), 32'd6);
        chk("combo_streak_restart", 32'(streak), 32'd1);
`else
        apply(1'b1, 18'h00007, 18'h00001);
        apply(1'b1, 18'h00007, '0);
        apply(1'b1, 18'h00007, 18'h00002);
        apply(1'b1, 18'h00007, '0);
        apply(1'b1, 18'h00007, 18'h00004);
        apply(1'b1, 18'h00007, '0);
        apply(1'b1, '0, '0);
        apply(1'b1, 18'h00001, 18'h00001);
        chk("plain_score4", 32'(score), 32'd4);
        chk("plain_streak0", 32'(streak), 32'd0);
        apply(1'b1, 18'h00001, '0);
`endif

        // Dropping game_active during lockout returns to idle.
        apply(1'b1, '0, '0);
        apply(1'b1, '0, 18'h00002);
        chk("late_miss_locked", 32'(locked_out), 32'd1);
        apply(1'b0, '0, '0);
        chk("lockout_abort", 32'(locked_out), 32'd0);
        apply(1'b0, '0, '0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
